// File: rtl/fifo_umbral_main_if.sv
// Handshake and status bundle between the bench driver, fifo_umbral_main and the VC demux stage.
// master drives push/pop/data/thresholds; slave is the FIFO itself.
interface fifo_umbral_main_if #(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 4
);
  logic                 push;
  logic [BITNUMBER-1:0] data_in;
  logic                 pop;
  logic [LENGTH-1:0]    Umbral_alto;
  logic [LENGTH-1:0]    Umbral_bajo;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid_out;
  logic                 pause;
  logic                 almost_empty;
  logic                 can_pop;
  logic                 full;
  logic                 empty;
  logic                 error;

  modport master (
    output push, data_in, pop, Umbral_alto, Umbral_bajo,
    input  data_out, valid_out, pause, almost_empty, can_pop, full, empty, error
  );

  modport slave (
    input  push, data_in, pop, Umbral_alto, Umbral_bajo,
    output data_out, valid_out, pause, almost_empty, can_pop, full, empty, error
  );
endinterface

// File: rtl/fifo_umbral_main.sv
// Main input FIFO of the transaction layer with programmable pause / almost-empty thresholds.
// Optional macro UMBRAL_LATCH_EN: thresholds are captured during reset and held afterwards.
module fifo_umbral_main #(
  parameter int BITNUMBER  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int LENGTH     = ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               reset,
  fifo_umbral_main_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BITNUMBER-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LENGTH-1:0]     count;
  logic [LENGTH-1:0]     count_nxt;
  logic [BITNUMBER-1:0]  data_out_q;
  logic                  valid_out_q;
  logic                  error_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_en;
  logic                  rd_en;
  logic [LENGTH-1:0]     alto_eff;
  logic [LENGTH-1:0]     bajo_eff;
  logic [LENGTH:0]       pause_lim;

`ifdef UMBRAL_LATCH_EN
  logic [LENGTH-1:0] alto_q;
  logic [LENGTH-1:0] bajo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      alto_q <= bus.Umbral_alto;
      bajo_q <= bus.Umbral_bajo;
    end
  end

  assign alto_eff = alto_q;
  assign bajo_eff = bajo_q;
`else
  assign alto_eff = bus.Umbral_alto;
  assign bajo_eff = bus.Umbral_bajo;
`endif

  assign full_w  = (count == LENGTH'(DEPTH));
  assign empty_w = (count == '0);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign wr_en = bus.push && (!full_w || bus.pop);
  assign rd_en = bus.pop && !empty_w;

  // NOTE: combinational blocks assign a default first so no path leaves count_nxt unassigned (no latch).
  always_comb begin
    count_nxt = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_nxt = count + LENGTH'(1);
      2'b01:   count_nxt = count - LENGTH'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      count       <= count_nxt;
      valid_out_q <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) begin
        rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
        data_out_q <= mem[rd_ptr];
      end
      if ((bus.push && full_w && !bus.pop) || (bus.pop && empty_w))
        error_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem[wr_ptr] <= bus.data_in;
  end

  // Limit may go negative (MSB set) when the threshold reaches DEPTH: pause is then permanent.
  assign pause_lim = (LENGTH + 1)'(DEPTH) - {1'b0, alto_eff};

  assign bus.pause        = !reset && (pause_lim[LENGTH] || ({1'b0, count} >= pause_lim));
  assign bus.almost_empty = (count <= bajo_eff);
  assign bus.can_pop      = !empty_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.error        = error_q;

endmodule
